jtag_scan_ctrl: RTL and testbench

Phase sequencer for the virtual-JTAG DUT test harness. It turns the virtual DR state strobes (`cdr`, `sdr`, `udr`) into alternating input-scan and output-scan transactions. It owns the input and output shift registers, applies a new stimulus vector to the DUT only when the scan length is exact, captures DUT responses, and reports protocol errors and transaction counts. It sits between the `v_jtag` instance and the DUT in the top level, and replaces the ad-hoc `io` toggle logic there.

---
 rtl/jtag_scan_ctrl_if.sv | 27 ++
 rtl/jtag_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_jtag_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// jtag_scan_ctrl_if
//   Virtual-JTAG DR-side signal bundle between the v_jtag instance (master)
//   and the scan phase sequencer (slave).
//
//   Signals:
//     cdr  - Capture-DR state strobe        (master -> slave)
//     sdr  - Shift-DR state strobe          (master -> slave)
//     udr  - Update-DR state strobe         (master -> slave)
//     tdi  - serial data from host, LSB 1st (master -> slave)
//     tdo  - serial data to host            (slave  -> master)
//
//   Handshake: there is no valid/ready pair. Each strobe is sampled on every
//   rising tck edge and acts on that edge only; when several are high
//   together, udr wins over cdr, which wins over sdr. The host samples tdo
//   before the tck edge that shifts it out.
// ---------------------------------------------------------------------------
interface jtag_scan_ctrl_if;
    logic cdr;
    logic sdr;
    logic udr;
    logic tdi;
    logic tdo;

    modport master (output cdr, output sdr, output udr, output tdi, input tdo);
    modport slave  (input cdr, input sdr, input udr, input tdi, output tdo);
endinterface

// File: rtl/jtag_scan_ctrl.sv
// ---------------------------------------------------------------------------
// jtag_scan_ctrl
//   Phase sequencer for the virtual-JTAG DUT harness. Alternates between an
//   input scan (host -> in_sr -> dut_input) and an output scan
//   (dut_output -> out_sr -> host). A stimulus vector is applied only when
//   exactly NUM_IN bits were shifted; bad scans set a sticky error flag.
//
//   Ports:
//     tck          - clock (virtual JTAG TCK), rising edge
//     rst          - synchronous active-high reset
//     jtag         - cdr/sdr/udr/tdi in, tdo out (slave modport)
//     dut_output   - DUT response vector, captured on cdr in output phase
//     dut_input    - registered stimulus vector
//     in_valid     - one-cycle pulse when dut_input is updated
//     out_captured - one-cycle pulse when dut_output is captured
//     phase        - 0 = input phase, 1 = output phase
//     err_clear    - clears shift_err (a new error on the same edge wins)
//     shift_err    - sticky bad-scan flag
//     vector_count - accepted input vectors, wraps at 16 bits
//     fsm_state    - debug view of the sequencer state
// ---------------------------------------------------------------------------
module jtag_scan_ctrl #(
    parameter int NUM_IN  = 8,
    parameter int NUM_OUT = 6
) (
    input  logic                tck,
    input  logic                rst,
    jtag_scan_ctrl_if.slave     jtag,
    input  logic [NUM_OUT-1:0]  dut_output,
    output logic [NUM_IN-1:0]   dut_input,
    output logic                in_valid,
    output logic                out_captured,
    output logic                phase,
    input  logic                err_clear,
    output logic                shift_err,
    output logic [15:0]         vector_count,
    output logic [1:0]          fsm_state
);

    // Bit 1 of the encoding is the phase, so phase is a plain register bit.
    typedef enum logic [1:0] {
        IN_WAIT   = 2'd0,
        IN_SHIFT  = 2'd1,
        OUT_WAIT  = 2'd2,
        OUT_SHIFT = 2'd3
    } state_t;

    localparam logic [7:0] IN_LEN  = 8'(NUM_IN);
    localparam logic [7:0] OUT_LEN = 8'(NUM_OUT);

    state_t               state_q;
    logic [NUM_IN-1:0]    in_sr_q;
    logic [NUM_OUT-1:0]   out_sr_q;
    logic [NUM_IN-1:0]    dut_input_q;
    logic [15:0]          vector_count_q;
    logic [7:0]           bit_cnt_q;
    logic                 cap_q;
    logic                 in_valid_q;
    logic                 out_captured_q;
    logic                 shift_err_q;

    logic [NUM_IN-1:0]    in_sr_d;
    logic [NUM_OUT-1:0]   out_sr_d;
    logic [7:0]           bit_cnt_d;
    logic                 in_len_ok;
    logic                 err_set;

    always_comb begin
        // Shift right with tdi entering at the MSB; written this way so that
        // a one-bit register is legal.
        in_sr_d            = in_sr_q >> 1;
        in_sr_d[NUM_IN-1]  = jtag.tdi;
        out_sr_d           = out_sr_q >> 1;
        // Counter saturates so an over-long scan can never wrap back to a
        // length that looks exact.
        bit_cnt_d          = (bit_cnt_q == 8'hFF) ? bit_cnt_q : bit_cnt_q + 8'd1;
        in_len_ok          = (bit_cnt_q == IN_LEN);
        err_set            = jtag.udr &&
                             (state_q[1] ? ((bit_cnt_q != OUT_LEN) || !cap_q)
                                         : !in_len_ok);
    end

    always_ff @(posedge tck) begin
        if (rst) begin
            state_q        <= IN_WAIT;
            in_sr_q        <= '0;
            out_sr_q       <= '0;
            dut_input_q    <= '0;
            vector_count_q <= '0;
            bit_cnt_q      <= '0;
            cap_q          <= 1'b0;
            in_valid_q     <= 1'b0;
            out_captured_q <= 1'b0;
            shift_err_q    <= 1'b0;
        end else begin
            in_valid_q     <= 1'b0;
            out_captured_q <= 1'b0;

            if (err_set) begin
                shift_err_q <= 1'b1;
            end else if (err_clear) begin
                shift_err_q <= 1'b0;
            end

            if (jtag.udr) begin
                // Every udr ends the current phase, good scan or not.
                bit_cnt_q <= '0;
                if (!state_q[1]) begin
                    if (in_len_ok) begin
                        dut_input_q    <= in_sr_q;
                        in_valid_q     <= 1'b1;
                        vector_count_q <= vector_count_q + 16'd1;
                    end
                    state_q <= OUT_WAIT;
                end else begin
                    cap_q   <= 1'b0;
                    state_q <= IN_WAIT;
                end
            end else if (jtag.cdr) begin
                // Capture only before the first output shift; a repeated
                // cdr in OUT_WAIT reloads.
                if (state_q == OUT_WAIT) begin
                    out_sr_q       <= dut_output;
                    out_captured_q <= 1'b1;
                    cap_q          <= 1'b1;
                end
            end else if (jtag.sdr) begin
                bit_cnt_q <= bit_cnt_d;
                if (!state_q[1]) begin
                    in_sr_q <= in_sr_d;
                    state_q <= IN_SHIFT;
                end else begin
                    out_sr_q <= out_sr_d;
                    state_q  <= OUT_SHIFT;
                end
            end
        end
    end

    assign jtag.tdo     = out_sr_q[0];
    assign dut_input    = dut_input_q;
    assign in_valid     = in_valid_q;
    assign out_captured = out_captured_q;
    assign phase        = state_q[1];
    assign shift_err    = shift_err_q;
    assign vector_count = vector_count_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jtag_scan_ctrl
//   Self-checking bench for jtag_scan_ctrl (NUM_IN=8, NUM_OUT=6).
//   Expected stimulus vectors and expected tdo bits are queued when the
//   stimulus is driven and popped when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_jtag_scan_ctrl;

    localparam int NI = 8;
    localparam int NO = 6;

    // ---------------- clock / reset ----------------
    logic tck = 1'b0;
    logic rst = 1'b1;
    always #5 tck = ~tck;

    jtag_scan_ctrl_if jif ();

    logic [NO-1:0] dut_output;
    logic [NI-1:0] dut_input;
    logic          in_valid;
    logic          out_captured;
    logic          phase;
    logic          err_clear;
    logic          shift_err;
    logic [15:0]   vector_count;
    logic [1:0]    fsm_state;

    jtag_scan_ctrl #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
        .tck          (tck),
        .rst          (rst),
        .jtag         (jif),
        .dut_output   (dut_output),
        .dut_input    (dut_input),
        .in_valid     (in_valid),
        .out_captured (out_captured),
        .phase        (phase),
        .err_clear    (err_clear),
        .shift_err    (shift_err),
        .vector_count (vector_count),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [NI-1:0] exp_q[$];
    logic          exp_tdo_q[$];
    int            vld_pulses = 0;
    int            cap_pulses = 0;
    int            exp_vld = 0;
    int            exp_cap = 0;
    logic [15:0]   exp_vc = '0;
    logic [NI-1:0] exp_din = '0;
    logic          exp_err = 1'b0;
    logic [NI-1:0] mon_e;

    // Monitor: every in_valid pulse must match the head of the expected queue.
    always @(posedge tck) begin
        #1;
        if (in_valid) begin
            vld_pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL in_valid_unexpected dut_input=%h", dut_input);
            end else begin
                mon_e = exp_q.pop_front();
                if (dut_input !== mon_e) begin
                    errors++;
                    $display("FAIL sb_dut_input got=%h exp=%h", dut_input, mon_e);
                end
            end
        end
        if (out_captured) cap_pulses++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic c, input logic s, input logic u,
                        input logic t, input logic ec);
        jif.cdr   = c;
        jif.sdr   = s;
        jif.udr   = u;
        jif.tdi   = t;
        err_clear = ec;
        @(posedge tck);
        #1;
    endtask

    task automatic input_txn(input int n, input logic [NI-1:0] v);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, v[i], 1'b0);
        if (n == NI) begin
            exp_q.push_back(v);
            exp_vld++;
            exp_vc  = exp_vc + 16'd1;
            exp_din = v;
        end else begin
            exp_err = 1'b1;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_input !== exp_din) begin errors++; $display("FAIL in_dut_input got=%h exp=%h", dut_input, exp_din); end
        checks++;
        if (in_valid !== (n == NI)) begin errors++; $display("FAIL in_valid got=%b exp=%b", in_valid, (n == NI)); end
        checks++;
        if (vector_count !== exp_vc) begin errors++; $display("FAIL in_vector_count got=%0d exp=%0d", vector_count, exp_vc); end
        checks++;
        if (phase !== 1'b1) begin errors++; $display("FAIL in_phase got=%b exp=1", phase); end
        checks++;
        if (shift_err !== exp_err) begin errors++; $display("FAIL in_shift_err got=%b exp=%b", shift_err, exp_err); end
    endtask

    task automatic output_txn(input logic do_cdr, input int n, input logic [NO-1:0] v);
        logic t;
        dut_output = v;
        if (do_cdr) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_cap++;
            checks++;
            if (out_captured !== 1'b1) begin errors++; $display("FAIL out_captured got=%b exp=1", out_captured); end
            for (int k = 0; k <= n; k++) exp_tdo_q.push_back((k < NO) ? v[k] : 1'b0);
            // Capture must hold even though the DUT output moves on.
            dut_output = ~v;
        end
        for (int k = 0; k <= n; k++) begin
            if (do_cdr) begin
                t = exp_tdo_q.pop_front();
                checks++;
                if (jif.tdo !== t) begin errors++; $display("FAIL tdo_bit%0d got=%b exp=%b", k, jif.tdo, t); end
            end
            if (k < n) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        if (!do_cdr || n != NO) exp_err = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (phase !== 1'b0) begin errors++; $display("FAIL out_phase got=%b exp=0", phase); end
        checks++;
        if (shift_err !== exp_err) begin errors++; $display("FAIL out_shift_err got=%b exp=%b", shift_err, exp_err); end
    endtask

    task automatic clear_err();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_err = 1'b0;
        checks++;
        if (shift_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", shift_err); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({dut_input, in_valid, out_captured, phase, shift_err, jif.tdo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs din=%h v=%b c=%b ph=%b e=%b tdo=%b exp=all0",
                     dut_input, in_valid, out_captured, phase, shift_err, jif.tdo);
        end
        checks++;
        if (vector_count !== 16'd0) begin errors++; $display("FAIL reset_vector_count got=%0d exp=0", vector_count); end
        checks++;
        if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
        rst = 1'b0;
    endtask

    task automatic test_input_scan();
        // tdi sequence 1,0,1,0,0,1,1,0 LSB first
        input_txn(NI, 8'h65);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_valid !== 1'b0) begin errors++; $display("FAIL in_valid_width got=%b exp=0", in_valid); end
    endtask

    task automatic test_output_scan();
        output_txn(1'b1, NO, 6'b101101);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cap_pulses !== exp_cap) begin errors++; $display("FAIL cap_pulses got=%0d exp=%0d", cap_pulses, exp_cap); end
    endtask

    task automatic test_short_scan();
        input_txn(NI - 1, 8'h3C);
        clear_err();
        // udr with err_clear: output phase with no capture sets the error again
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (shift_err !== 1'b1) begin errors++; $display("FAIL err_set_over_clear got=%b exp=1", shift_err); end
        checks++;
        if (phase !== 1'b0) begin errors++; $display("FAIL err_udr_phase got=%b exp=0", phase); end
        clear_err();
    endtask

    task automatic test_no_capture();
        input_txn(NI, 8'($urandom_range(0, 255)));
        output_txn(1'b0, NO, 6'h2A);
        clear_err();
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_vc  = '0;
        exp_din = '0;
        exp_err = 1'b0;
        checks++;
        if ({dut_input, in_valid, out_captured, phase, shift_err} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs din=%h v=%b c=%b ph=%b e=%b exp=all0",
                     dut_input, in_valid, out_captured, phase, shift_err);
        end
        checks++;
        if (vector_count !== 16'd0) begin errors++; $display("FAIL midrst_vector_count got=%0d exp=0", vector_count); end
        input_txn(NI, 8'hFF);
        output_txn(1'b1, NO, 6'($urandom_range(0, 63)));
    endtask

    task automatic test_back_to_back();
        logic [NI-1:0] v;
        v = 8'($urandom_range(0, 255));
        for (int i = 0; i < NI; i++) step(1'b0, 1'b1, 1'b0, v[i], 1'b0);
        exp_q.push_back(v);
        exp_vld++;
        exp_vc  = exp_vc + 16'd1;
        exp_din = v;
        // udr and sdr together: update wins, no extra shift
        step(1'b0, 1'b1, 1'b1, ~v[NI-1], 1'b0);
        checks++;
        if (dut_input !== v) begin errors++; $display("FAIL b2b_dut_input got=%h exp=%h", dut_input, v); end
        checks++;
        if (fsm_state !== 2'd2) begin errors++; $display("FAIL b2b_state got=%0d exp=2", fsm_state); end
        checks++;
        if (shift_err !== 1'b0) begin errors++; $display("FAIL b2b_err got=%b exp=0", shift_err); end
        // consecutive udr edges each toggle phase
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (phase !== 1'b0 || shift_err !== 1'b1) begin errors++; $display("FAIL b2b_udr2 phase=%b err=%b exp=0,1", phase, shift_err); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (phase !== 1'b1 || dut_input !== v || vector_count !== exp_vc) begin
            errors++;
            $display("FAIL b2b_udr3 phase=%b din=%h vc=%0d exp=1,%h,%0d", phase, dut_input, vector_count, v, exp_vc);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (phase !== 1'b0) begin errors++; $display("FAIL b2b_udr4 phase=%b exp=0", phase); end
        clear_err();
    endtask

    task automatic test_random_pairs();
        for (int i = 0; i < 20; i++) begin
            input_txn(NI, 8'($urandom_range(0, 255)));
            output_txn(1'b1, NO, 6'($urandom_range(0, 63)));
        end
    endtask

    task automatic test_final();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        checks++;
        if (vld_pulses != exp_vld) begin errors++; $display("FAIL vld_pulses got=%0d exp=%0d", vld_pulses, exp_vld); end
        checks++;
        if (cap_pulses != exp_cap) begin errors++; $display("FAIL cap_total got=%0d exp=%0d", cap_pulses, exp_cap); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        jif.cdr    = 1'b0;
        jif.sdr    = 1'b0;
        jif.udr    = 1'b0;
        jif.tdi    = 1'b0;
        err_clear  = 1'b0;
        dut_output = '0;
        test_reset();
        test_input_scan();
        test_output_scan();
        test_short_scan();
        test_no_capture();
        test_reset_mid_scan();
        test_back_to_back();
        test_random_pairs();
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
